// File: rtl/demux_scan.sv
// Registered 1-to-4 demultiplexer with direct-select and round-robin scan modes.
// Optional build macro DEMUX_CLEAR_ON_DISABLE_EN: clear o0..o3 on every edge spent in IDLE.
module demux_scan #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic             scan,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  output logic             frame_done,
  output logic [1:0]       ch
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q [4];
  logic [WIDTH-1:0] o_d [4];
  logic [3:0]       v_q, v_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;

  always_comb begin
    ready  = (state_q != IDLE) && e;
    accept = ready && d_valid;

    case (state_q)
      DIRECT:  ch = {s0, s1};
      SCAN:    ch = cnt_q;
      default: ch = 2'd0;
    endcase

    if (!e) begin
      state_d = IDLE;
    end else if (scan) begin
      state_d = SCAN;
    end else begin
      state_d = DIRECT;
    end

    // Counter only advances while staying in SCAN; any fresh entry restarts the frame.
    if (state_d != SCAN || state_q != SCAN) begin
      cnt_d = 2'd0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
    end else begin
      cnt_d = cnt_q;
    end

    frame_done_d = accept && (state_q == SCAN) && (cnt_q == 2'd3);

    v_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      o_d[i] = o_q[i];
`ifdef DEMUX_CLEAR_ON_DISABLE_EN
      if (state_q == IDLE) begin
        o_d[i] = '0;
      end
`endif
      if (accept && (ch == 2'(i))) begin
        o_d[i] = d;
        v_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      v_q          <= 4'b0000;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        o_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      v_q          <= v_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 4; i++) begin
        o_q[i] <= o_d[i];
      end
    end
  end

  assign o0         = o_q[0];
  assign o1         = o_q[1];
  assign o2         = o_q[2];
  assign o3         = o_q[3];
  assign v0         = v_q[0];
  assign v1         = v_q[1];
  assign v2         = v_q[2];
  assign v3         = v_q[3];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_scan.sv
// Self-checking bench for demux_scan: directed scenarios plus random traffic
// compared against a behavioural model of the channel-routing rules.
module tb_demux_scan;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         e = 1'b0, scan = 1'b0, s0 = 1'b0, s1 = 1'b0, d_valid = 1'b0;
  logic [W-1:0] d = '0;
  logic         ready, v0, v1, v2, v3, frame_done;
  logic [W-1:0] o0, o1, o2, o3;
  logic [1:0]   ch;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = disabled, 1 = direct, 2 = scan; pos = next scan slot.
  int           m_mode = 0;
  int           m_pos  = 0;
  logic [W-1:0] m_o [4];

  demux_scan #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .e(e), .scan(scan), .s0(s0), .s1(s1),
    .d(d), .d_valid(d_valid), .ready(ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .frame_done(frame_done), .ch(ch)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pos  = 0;
    for (int i = 0; i < 4; i++) m_o[i] = '0;
  endtask

  // One clock of traffic, entered and left just after a falling edge.
  task automatic beat(input logic ie, input logic isc, input logic is0, input logic is1,
                      input logic [W-1:0] id, input logic idv);
    int       tgt;
    bit       acc;
    bit       fd;
    logic [3:0] ev;
    e = ie; scan = isc; s0 = is0; s1 = is1; d = id; d_valid = idv;
    #1;
    tgt = (m_mode == 0) ? 0 : (m_mode == 1) ? (int'(is0) * 2 + int'(is1)) : m_pos;
    check_val("ready", ready, (m_mode != 0) && ie);
    check_val("ch", ch, tgt);

    acc = (m_mode != 0) && ie && idv;
    ev  = acc ? 4'(1 << tgt) : 4'b0000;
    fd  = acc && (m_mode == 2) && (m_pos == 3);
`ifdef DEMUX_CLEAR_ON_DISABLE_EN
    if (m_mode == 0) for (int i = 0; i < 4; i++) m_o[i] = '0;
`endif
    if (acc) m_o[tgt] = id;
    if (acc && m_mode == 2) m_pos = (m_pos + 1) % 4;
    begin
      int nxt;
      nxt = !ie ? 0 : (isc ? 2 : 1);
      if (nxt != 2 || m_mode != 2) m_pos = 0;
      m_mode = nxt;
    end

    @(posedge clk);
    #1;
    $display("beat e=%0b scan=%0b sel=%0d d=%0h dv=%0b | o=%0h %0h %0h %0h v=%0b%0b%0b%0b fd=%0b",
             ie, isc, {is0, is1}, id, idv, o0, o1, o2, o3, v3, v2, v1, v0, frame_done);
    check_val("o0", o0, m_o[0]);
    check_val("o1", o1, m_o[1]);
    check_val("o2", o2, m_o[2]);
    check_val("o3", o3, m_o[3]);
    check_val("v", {v3, v2, v1, v0}, ev);
    check_val("frame_done", frame_done, fd);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    check_val("rst_o", {o3, o2, o1, o0}, 0);
    check_val("rst_v", {v3, v2, v1, v0, frame_done}, 0);
    check_val("rst_ready", ready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    async_reset();

    // Direct mode: all four channels in order.
    beat(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) beat(1, 0, i[1], i[0], 4'h1, 1);

    // Disabled with valid data: ignored, then ready returns one cycle after e.
    for (int i = 0; i < 4; i++) beat(0, 0, 1, 1, 4'h1, 1);
    beat(1, 0, 0, 0, 4'h7, 1);
    beat(1, 0, 0, 0, 4'h7, 0);

    // Scan frame A..D then wrap to o0.
    beat(1, 1, 0, 0, 0, 0);
    beat(1, 1, 0, 0, 4'hA, 1);
    beat(1, 1, 0, 0, 4'hB, 1);
    beat(1, 1, 0, 0, 4'hC, 1);
    beat(1, 1, 0, 0, 4'hD, 1);
    beat(1, 1, 0, 0, 4'hE, 1);

    // Abandon partial frame: leave and re-enter scan.
    beat(1, 1, 0, 0, 4'h3, 1);
    beat(1, 1, 0, 0, 4'h4, 1);
    beat(1, 0, 0, 0, 4'h0, 0);
    beat(1, 1, 0, 0, 4'h0, 0);
    beat(1, 1, 0, 0, 4'h9, 1);

    // Reset mid-frame, first accept afterwards lands on channel 0.
    beat(1, 1, 0, 0, 4'h5, 1);
    beat(1, 1, 0, 0, 4'h6, 1);
    async_reset();
    beat(1, 1, 0, 0, 4'h0, 0);
    beat(1, 1, 0, 0, 4'h8, 1);

    // Fill with 1 in direct mode, then disable for two cycles.
    beat(1, 0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 4; i++) beat(1, 0, i[1], i[0], 4'h1, 1);
    beat(0, 0, 0, 0, 4'h0, 0);
    beat(0, 0, 0, 0, 4'h0, 0);
`ifdef DEMUX_CLEAR_ON_DISABLE_EN
    check_val("idle_clear", {o3, o2, o1, o0}, 16'h0000);
`else
    check_val("idle_hold", {o3, o2, o1, o0}, 16'h1111);
`endif

    // Random traffic with sticky mode bits.
    begin
      logic re, rsc;
      re = 1; rsc = 0;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 7) == 0) rsc = ~rsc;
        re = ($urandom_range(0, 9) != 0);
        beat(re, rsc, 1'($urandom), 1'($urandom), W'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_scan.md
# demux_scan

Registered 1-to-4 demultiplexer with enable: the receive-side counterpart of the team's 4:1 enabled mux. Words arriving on `d` are routed to one of four held output registers, either by direct select (`s0`, `s1`, same encoding as the mux) or by an internal round-robin scan counter that fills channels 0→3 and flags each complete frame. Sits at the far end of a time-multiplexed link, rebuilding parallel channels from the mux's serial stream.

## Interface
- `WIDTH`, default 1: data word width in bits.

- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous reset, active-high
- `e`  input  1  enable; 0 forces IDLE and blocks acceptance
- `scan`  input  1  1 = round-robin scan mode, 0 = direct select
- `s0`  input  1  select MSB (direct mode)
- `s1`  input  1  select LSB (direct mode)
- `d`  input  WIDTH  input data word
- `d_valid`  input  1  `d` valid this cycle
- `ready`  output  1  combinational: `(state != IDLE) && e`
- `o0`..`o3`  output  WIDTH each  held channel registers
- `v0`..`v3`  output  1 each  one-cycle strobe: matching `oN` updated
- `frame_done`  output  1  one-cycle strobe: scan frame completed
- `ch`  output  2  current target channel

## Operation
- Channel index in direct mode = {s0, s1}, so s0 is the MSB: (s0=0,s1=1)→ch1; (s0=1,s1=0)→ch2; (1,1)→ch3.
- FSM states: IDLE, DIRECT, SCAN.
  - Any state with e=0 goes to IDLE on the next edge.
  - From IDLE with e=1: go to SCAN if scan=1, else DIRECT.
  - From DIRECT with scan=1: go to SCAN.
  - From SCAN with scan=0: go to DIRECT.
  - The scan counter clears to 0 on every entry into SCAN.
- Accept = `ready && d_valid`. On accept, `o[ch] <= d` and `v[ch] <= 1`; all other `vN` are 0. Non-addressed `oN` hold.
- `ch` is 0 in IDLE, {s0,s1} in DIRECT, and the scan counter in SCAN.
- SCAN: the counter increments (mod 4) on each accept. An accept with counter=3 wraps it to 0 and sets `frame_done` for one cycle, coincident with `v3`.
- Leaving SCAN mid-frame abandons the partial frame: no `frame_done`, and filled registers keep their values.
- `d_valid` without `ready` is ignored: no register change, no strobe.

## Timing
- Reset (asynchronous): state IDLE, counter 0, `o0`..`o3`=0, `v0`..`v3`=0, `frame_done`=0. Reset mid-frame discards the frame immediately.
- Latency: `oN`/`vN` update on the edge that samples the accept, so they are visible one cycle after the `d`/`d_valid` beat.
- After e rises, `ready` goes high one cycle later (the IDLE→active edge). When e falls, `ready` drops in the same cycle (combinational), so no word is accepted.
- `s0`/`s1` are sampled with `d`. Changing them between beats retargets the next word with no bubble.
- In SCAN, back-to-back accepts run one word per cycle. A full frame takes 4 accepts and `frame_done` fires every 4th.
- `scan` toggling in the same cycle as an accept: the word goes to the current `ch`, and the mode change takes effect on the next edge.

## Configuration
- `DEMUX_CLEAR_ON_DISABLE_EN`
  - Defined: on every edge where the state is IDLE, `o0`..`o3` are cleared to 0, mirroring the mux's output-forced-0 when e=0.
  - Undefined: `o0`..`o3` hold their last values through IDLE, and only `rst` clears them.
  - Strobes and FSM behaviour are identical in both builds.

## Test plan
- Reset, then e=1, scan=0. Send four beats d=1 with {s0,s1} = 00, 01, 10, 11 in turn → `v0`, `v1`, `v2`, `v3` pulse in order, `o0`..`o3`=1, `ch` tracks 0, 1, 2, 3, `frame_done` stays 0.
- e=0 with d_valid=1, d=1 for 4 cycles → `ready`=0, no strobes, outputs unchanged. Then raise e=1 → `ready`=1 exactly one cycle later.
- WIDTH=4, scan=1, back-to-back d=4'hA, B, C, D → `o0`..`o3`=A, B, C, D, `frame_done` high only in the cycle with `v3`. A 5th beat 4'hE lands in `o0`.
- Scan mode: two words accepted, then scan=0 for 1 cycle, then scan=1 → no `frame_done`, the counter restarts at 0, and the next word overwrites `o0`.
- Assert `rst` mid-frame after 2 scan accepts → all outputs 0 immediately (asynchronously). After release with e=1, the first accept targets channel 0.
- Load all channels with 1, then set e=0 for 2 cycles → outputs stay 1 without `DEMUX_CLEAR_ON_DISABLE_EN`, and read 0 with it defined.
